// File: rtl/spi_slave_8.sv
// -----------------------------------------------------------------------------
// spi_slave_8
//
// Byte-wide SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) with a CPU register
// port. SCLK, SS_n and MOSI are oversampled in the clk domain. Received bytes
// land in an RX holding register. Transmit bytes come from a TX holding
// register and are shifted out on MISO. The register map and status layout
// match the SPI master, so one driver style serves both ends of the link.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   SCLK, SS_n      SPI clock and active-low select from the master (async)
//   MOSI            serial data from the master
//   MISO, MISO_oe   serial data to the master and its pad tri-state enable
//   mem_addr        register address (0 rxdata, 1 txdata, 2 status, 3 control)
//   data_from_cpu   write data
//   read_n, write_n active-low access strobes, qualified by spi_select
//   spi_select      register port chip select
//   data_to_cpu     registered read data
//   irq             registered interrupt request
//   dataavailable   RRDY
//   readyfordata    TRDY
// -----------------------------------------------------------------------------
module spi_slave_8 #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  // A single flop cannot be a safe synchronizer, so never build fewer than two.
  localparam int          STAGES    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [3:0]  LAST_BIT  = 4'(DATABITS - 1);
  localparam logic [15:0] CTRL_MASK = 16'h03D8;

  logic [STAGES-1:0]   sclk_sync;
  logic [STAGES-1:0]   ss_sync;
  logic [STAGES-1:0]   mosi_sync;
  logic                sclk_d;
  logic                ss_d;

  logic                sclk_s;
  logic                ss_s;
  logic                mosi_s;
  logic                selected;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                ss_fall;
  logic                ss_rise;

  logic [3:0]          bit_cnt;
  logic [DATABITS-1:0] rx_shift;
  logic [DATABITS-1:0] rx_holding;
  logic [DATABITS-1:0] tx_shift;
  logic [DATABITS-1:0] tx_holding;
  logic                tx_primed;
  logic                rrdy;
  logic                roe;
  logic                toe;
  logic                tur;
  logic [15:0]         ctrl;

  logic                rd;
  logic                wr;
  logic                rd_rx;
  logic                wr_tx;
  logic                wr_status;
  logic                wr_ctrl;
  logic                byte_done;
  logic                tx_load;
  logic                tx_accept;
  logic                tx_overrun;
  logic [DATABITS-1:0] rx_next;
  logic [15:0]         status;
  logic [15:0]         read_mux;

  // Input synchronizers plus one edge-detect register. SS_n idles high and
  // SCLK idles low after reset so no spurious edge is seen on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[STAGES-2:0], MOSI};
      sclk_d    <= sclk_sync[STAGES-1];
      ss_d      <= ss_sync[STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[STAGES-1];
  assign ss_s      = ss_sync[STAGES-1];
  assign mosi_s    = mosi_sync[STAGES-1];
  assign selected  = ~ss_s;
  assign sclk_rise = sclk_s & ~sclk_d & selected;
  assign sclk_fall = ~sclk_s & sclk_d & selected;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  assign rd        = spi_select & ~read_n;
  assign wr        = spi_select & ~write_n;
  assign rd_rx     = rd & (mem_addr == 3'd0);
  assign wr_tx     = wr & (mem_addr == 3'd1);
  assign wr_status = wr & (mem_addr == 3'd2);
  assign wr_ctrl   = wr & (mem_addr == 3'd3);

  assign rx_next   = {rx_shift[DATABITS-2:0], mosi_s};
  assign byte_done = sclk_rise & (bit_cnt == LAST_BIT);

  // The transmit shifter reloads at frame start and again on the falling edge
  // that closes each byte, which is what allows back-to-back bytes.
  assign tx_load    = ss_fall | (sclk_fall & (bit_cnt == 4'd0));
  // The acceptance test uses the pre-load primed flag, so a write landing in
  // the same cycle as a load primes the following byte instead.
  assign tx_accept  = wr_tx & ~tx_primed;
  assign tx_overrun = wr_tx & tx_primed;

  always_comb begin
    status    = '0;
    status[3] = roe;
    status[4] = toe;
    status[5] = ~tx_primed & ss_s;
    status[6] = ~tx_primed;
    status[7] = rrdy;
    status[8] = roe | toe | tur;
    status[9] = tur;
  end

  always_comb begin
    read_mux = '0;
    case (mem_addr)
      3'd0:    read_mux = {{(16 - DATABITS){1'b0}}, rx_holding};
      3'd2:    read_mux = status;
      3'd3:    read_mux = ctrl;
      default: read_mux = '0;
    endcase
  end

  // Serial datapath, holding registers and flags. Flag sets take priority
  // over the clears from CPU accesses in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_holding  <= '0;
      tx_shift    <= '0;
      tx_holding  <= '0;
      tx_primed   <= 1'b0;
      rrdy        <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tur         <= 1'b0;
      ctrl        <= '0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
    end else begin
      if (ss_fall || ss_rise) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
      end

      if (sclk_rise) begin
        rx_shift <= rx_next;
      end

      if (byte_done) begin
        rx_holding <= rx_next;
      end

      if (byte_done) begin
        rrdy <= 1'b1;
      end else if (rd_rx) begin
        rrdy <= 1'b0;
      end

      // A read of rxdata in the completion cycle consumes the old byte, so
      // the new one is not an overrun.
      if (byte_done && rrdy && !rd_rx) begin
        roe <= 1'b1;
      end else if (wr_status) begin
        roe <= 1'b0;
      end

      if (tx_overrun) begin
        toe <= 1'b1;
      end else if (wr_status) begin
        toe <= 1'b0;
      end

      if (tx_load && !tx_primed) begin
        tur <= 1'b1;
      end else if (wr_status) begin
        tur <= 1'b0;
      end

      if (tx_load) begin
        tx_shift <= tx_primed ? tx_holding : '0;
      end else if (sclk_fall) begin
        tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};
      end

      if (tx_accept) begin
        tx_primed  <= 1'b1;
        tx_holding <= data_from_cpu[DATABITS-1:0];
      end else if (tx_load) begin
        tx_primed <= 1'b0;
      end

      if (wr_ctrl) begin
        ctrl <= data_from_cpu & CTRL_MASK;
      end

      if (rd) begin
        data_to_cpu <= read_mux;
      end

      // TMT (bit 5) has no enable, so it never reaches irq.
      irq <= |(status & ctrl);
    end
  end

  assign MISO          = tx_shift[DATABITS-1] & selected;
  assign MISO_oe       = selected;
  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_primed;

endmodule
